// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: width-independent
// Gray/binary conversion on zero-extended values, the default pointer type and the depth.
package fifo_pkg;

    localparam int DEF_ASIZE = 4;
    localparam int DEPTH     = 2 ** DEF_ASIZE;
    localparam int MAX_PW    = 32;

    typedef logic [DEF_ASIZE:0] ptr_t;

    function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs give the correct result for any width up to MAX_PW.
    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
        logic [MAX_PW-1:0] b;
        b[MAX_PW-1] = g[MAX_PW-1];
        for (int i = MAX_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_sync_2ff.sv
// W-bit two-flop synchroniser with synchronous active-high reset to zero.
// Shared by the write- and read-side pointer controllers.
module sync_2ff #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rstp,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] rq1_q;
    logic [W-1:0] rq2_q;

    always_ff @(posedge clk) begin
        if (rstp) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= d;
            rq2_q <= rq1_q;
        end
    end

    assign q = rq2_q;

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO (write clock domain only).
// Optional fill level / almost-full outputs are built when FIFO_WPTR_LEVEL_EN is defined.
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic           clk,
    input  logic           rstp,
    input  logic           wr_en,
    input  logic [ASIZE:0] rd_gray_ptr,
    input  logic           clr_ovf,
    output logic           wr_mem_en,
    output logic [ASIZE-1:0] wr_addr,
    output logic [ASIZE:0] wr_gray_ptr,
    output logic           wr_full,
    output logic           wr_overflow,
    output logic [ASIZE:0] wr_level,
    output logic           wr_almost_full
);

    typedef logic [ASIZE:0] wptr_t;

    wptr_t rq2;
    wptr_t wbin_q, wbin_d;
    wptr_t wgray_q, wgray_d;
    logic  full_q, full_d;
    logic  ovf_q, ovf_d;
    logic  inc;

    sync_2ff #(.W(ASIZE + 1)) u_rptr_sync (
        .clk  (clk),
        .rstp (rstp),
        .d    (rd_gray_ptr),
        .q    (rq2)
    );

    // No RAM write while reset is held, even though the flags already read 0.
    assign inc = wr_en & ~full_q & ~rstp;

    always_comb begin
        wbin_d  = wbin_q + {{ASIZE{1'b0}}, inc};
        wgray_d = wptr_t'(bin2gray(MAX_PW'(wbin_d)));
        // Full when the next write pointer has lapped the synchronised read pointer.
        full_d  = (wgray_d == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]});
        ovf_d   = (wr_en & full_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_mem_en   = inc;
    assign wr_addr     = wbin_q[ASIZE-1:0];
    assign wr_gray_ptr = wgray_q;
    assign wr_full     = full_q;
    assign wr_overflow = ovf_q;

`ifdef FIFO_WPTR_LEVEL_EN
    localparam wptr_t DEPTH_L = wptr_t'(2 ** ASIZE);

    wptr_t rbin_s;
    wptr_t level_q, level_d;
    wptr_t free_cnt;
    logic  af_q, af_d;

    always_comb begin
        rbin_s   = wptr_t'(gray2bin(MAX_PW'(rq2)));
        level_d  = wbin_d - rbin_s;
        free_cnt = DEPTH_L - level_d;
        af_d     = (int'(free_cnt) <= AF_MARGIN);
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
        end
    end

    assign wr_level       = level_q;
    assign wr_almost_full = af_q;
`else
    assign wr_level       = '0;
    assign wr_almost_full = 1'b0;
`endif

endmodule
